shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched.sv | 114 +++++++++++
 tb/tb_shift_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// Two-requester left-shift scheduler: round-robin arbitration into one shared
// shifter stage that moves up to 3 bit positions per cycle.
module shift_sched #(
    parameter int W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0,
    input  logic [W-1:0]         A0,
    input  logic [$clog2(W)-1:0] N0,
    input  logic                 REQ1,
    input  logic [W-1:0]         A1,
    input  logic [$clog2(W)-1:0] N1,
    output logic                 ACK0,
    output logic                 ACK1,
    output logic                 BUSY,
    output logic [W-1:0]         Y,
    output logic                 DONE,
    output logic                 ID
);
    localparam int NW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          owner_q, owner_d;
    logic          ptr_q, ptr_d;
    logic [W-1:0]  y_q, y_d;
    logic          id_q, id_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [NW-1:0] step;
    logic          grant1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
            y_q     <= '0;
            id_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            id_q    <= id_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        id_d    = id_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        step    = (rem_q > NW'(3)) ? NW'(3) : rem_q;
        // ptr_q holds the last granted requester; the other one wins a tie
        grant1  = REQ1 && (!REQ0 || !ptr_q);
        unique case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    acc_d   = grant1 ? A1 : A0;
                    rem_d   = grant1 ? N1 : N0;
                    owner_d = grant1;
                    ptr_d   = grant1;
                    ack0_d  = !grant1;
                    ack1_d  = grant1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = acc_q << step;
                rem_d = rem_q - step;
                if (rem_q == step) begin
                    y_d     = acc_q << step;
                    id_d    = owner_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ACK0 = ack0_q;
    assign ACK1 = ack1_q;
    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_DONE);
    assign Y    = y_q;
    assign ID   = id_q;
endmodule

// File: tb/tb_shift_sched.sv
// Randomized bench for shift_sched against a job-level reference model
// (arbitration winner, A<<N result and ceil(N/3) shift latency).
module tb_shift_sched;
    localparam int W  = 8;
    localparam int NW = $clog2(W);

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1;
    logic [W-1:0]  A0, A1;
    logic [NW-1:0] N0, N1;
    logic          ACK0, ACK1, BUSY, DONE, ID;
    logic [W-1:0]  Y;

    int            total = 0;
    int            bad = 0;
    logic          last_g;
    logic [W-1:0]  exp_y;
    logic          exp_id;

    shift_sched #(.W(W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .A0(A0), .N0(N0),
        .REQ1(REQ1), .A1(A1), .N1(N1),
        .ACK0(ACK0), .ACK1(ACK1), .BUSY(BUSY),
        .Y(Y), .DONE(DONE), .ID(ID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int n);
        logic [2*W-1:0] t;
        t = {{W{1'b0}}, a} << n;
        return t[W-1:0];
    endfunction

    function automatic int ref_cycles(input int n);
        return (n == 0) ? 1 : (n + 2) / 3;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_y"}, Y, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_id"}, ID, 0);
        chk({tag, "_acks"}, {ACK0, ACK1}, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    // Entered at a negedge while the DUT is idle with at least one REQ high;
    // returns at the negedge of the idle cycle that follows DONE.
    task automatic serve(input bit keep, input bit raise_other);
        logic         w;
        logic [W-1:0] a;
        int           n;
        int           k;
        w = (REQ0 && REQ1) ? ~last_g : REQ1;
        a = w ? A1 : A0;
        n = w ? int'(N1) : int'(N0);
        @(negedge CLK);
        chk("ack0", ACK0, !w);
        chk("ack1", ACK1, w);
        chk("busy_ack", BUSY, 1);
        last_g = w;
        if (!keep) begin
            if (w) REQ1 = 1'b0; else REQ0 = 1'b0;
        end
        if (raise_other) begin
            if (w && !REQ0) begin
                REQ0 = 1'b1; A0 = W'($urandom); N0 = NW'($urandom_range(0, W-1));
            end else if (!w && !REQ1) begin
                REQ1 = 1'b1; A1 = W'($urandom); N1 = NW'($urandom_range(0, W-1));
            end
        end
        k = 0;
        do begin
            @(negedge CLK);
            k++;
            if (!DONE) begin
                chk("y_hold", Y, exp_y);
                chk("id_hold", ID, exp_id);
                chk("no_ack_busy", {ACK0, ACK1}, 0);
            end
        end while (!DONE && k < 40);
        chk("latency", k, ref_cycles(n));
        exp_y  = ref_shift(a, n);
        exp_id = w;
        chk("y", Y, exp_y);
        chk("id", ID, exp_id);
        chk("busy_done", BUSY, 1);
        chk("no_ack_done", {ACK0, ACK1}, 0);
        @(negedge CLK);
        chk("done_pulse", DONE, 0);
        chk("busy_idle", BUSY, 0);
        chk("no_ack_idle", {ACK0, ACK1}, 0);
        chk("y_idle", Y, exp_y);
        chk("id_idle", ID, exp_id);
    endtask

    task automatic set0(input logic [W-1:0] a, input int n);
        REQ0 = 1'b1; A0 = a; N0 = NW'(n);
    endtask

    task automatic set1(input logic [W-1:0] a, input int n);
        REQ1 = 1'b1; A1 = a; N1 = NW'(n);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        chk_zero("rst");
        @(negedge CLK);
        RST = 1'b0;
        last_g = 1'b1;
        exp_y  = '0;
        exp_id = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = '0; A1 = '0; N0 = '0; N1 = '0;
        last_g = 1'b1; exp_y = '0; exp_id = 1'b0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;

        set0(8'h01, 7); serve(0, 0);
        chk("c030_y", Y, 8'h80);
        set1(8'hA5, 0); serve(0, 0);
        chk("c031_y", Y, 8'hA5);
        set0(8'h81, 3); serve(0, 0);
        chk("c032a_y", Y, 8'h08);
        set0(8'h81, 6); serve(0, 0);
        chk("c032b_y", Y, 8'h40);

        @(negedge CLK);
        pulse_reset();
        set0(8'hFF, 4); set1(8'h0F, 2);
        serve(1, 0);
        chk("c033a_y", Y, 8'hF0);
        chk("c033a_id", ID, 0);
        serve(1, 0);
        chk("c033b_y", Y, 8'h3C);
        chk("c033b_id", ID, 1);
        serve(1, 0);
        serve(1, 0);
        REQ0 = 1'b0; REQ1 = 1'b0;

        set0(8'h3C, 5); serve(0, 1);
        serve(0, 0);

        // reset lands in the second SHIFT cycle of an N=7 job
        set0(8'h01, 7);
        @(negedge CLK);
        chk("c035_ack", ACK0, 1);
        REQ0 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_zero("c035_rst");
        @(negedge CLK);
        RST = 1'b0;
        last_g = 1'b1; exp_y = '0; exp_id = 1'b0;
        set1(8'h03, 2); serve(0, 0);
        chk("c035_next_y", Y, 8'h0C);
        repeat (2) begin
            @(negedge CLK);
            chk("quiet_done", DONE, 0);
        end

        for (int it = 0; it < 80; it++) begin
            if (!REQ0 && $urandom_range(0, 1) == 1)
                set0(W'($urandom), int'($urandom_range(0, W-1)));
            if (!REQ1 && $urandom_range(0, 1) == 1)
                set1(W'($urandom), int'($urandom_range(0, W-1)));
            if (!REQ0 && !REQ1)
                set0(W'($urandom), int'($urandom_range(0, W-1)));
            serve($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
